// File: rtl/button_conditioner_pkg.sv
// Shared types for the pushbutton conditioning block.
package button_conditioner_pkg;

    localparam int unsigned NUM_BUTTONS = 3;

    typedef logic [NUM_BUTTONS-1:0] ButtonVec;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } ButtonDebounceState;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 2;

    // Debounced level is high while the button is accepted as pressed.
    function automatic logic is_high_state(input ButtonDebounceState s);
        return (s == IDLE_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/button_conditioner_debouncer.sv
// Single-button synchronizer, debounce FSM and registered level/press outputs.
module ButtonDebouncer
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_c
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic               sync_meta;
    logic               sync_bit;
    ButtonDebounceState state;
    ButtonDebounceState state_next;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic               level_next;

    // Two-flop synchronizer; only sync_bit feeds the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_bit  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_bit  <= sync_meta;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_LOW;
            count <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            level <= level_next;
            press <= press_c;
        end
    end

    // Next state: a level change needs DEBOUNCE_CYCLES stable samples after the first.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE_LOW: begin
                if (sync_bit) begin
                    state_next = WAIT_HIGH;
                    count_next = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_bit) begin
                    state_next = IDLE_LOW;
                    count_next = '0;
                end else if (count == LAST) begin
                    state_next = IDLE_HIGH;
                    count_next = '0;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            IDLE_HIGH: begin
                if (!sync_bit) begin
                    state_next = WAIT_LOW;
                    count_next = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_bit) begin
                    state_next = IDLE_HIGH;
                    count_next = '0;
                end else if (count == LAST) begin
                    state_next = IDLE_LOW;
                    count_next = '0;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: begin
                state_next = IDLE_LOW;
                count_next = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so level and press land on the accepting edge.
    always_comb begin
        level_next = is_high_state(state_next);
        press_c    = (state == WAIT_HIGH) && (state_next == IDLE_HIGH);
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the three board pushbuttons and keeps a software-clearable press flag.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btnRaw,
    input  logic [NUM_BUTTONS-1:0] pressClear,
    output logic [NUM_BUTTONS-1:0] btnLevel,
    output logic [NUM_BUTTONS-1:0] btnPress,
    output logic [NUM_BUTTONS-1:0] btnSticky
);

    ButtonVec press_set;

    // One independent debouncer per button.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        ButtonDebouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk     (clk),
            .rst     (rst),
            .raw     (btnRaw[i]),
            .level   (btnLevel[i]),
            .press   (btnPress[i]),
            .press_c (press_set[i])
        );
    end

    // Sticky press flag; a new press wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnSticky <= '0;
        end else begin
            btnSticky <= press_set | (btnSticky & ~pressClear);
        end
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), stable-sample count required before a level change is accepted; legal range 2 to 2^24.
REQ-002 clk  input  1  single clock shared with the CPU and memories; every flop is clocked on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; all state clears immediately on assertion.
REQ-004 btnRaw  input  3  raw pushbutton pins: bit0 = btnC, bit1 = btnU, bit2 = btnD; asynchronous to clk.
REQ-005 pressClear  input  3  per-button clear request from IOCtrl, one cycle, issued when software reads the button status.
REQ-006 btnLevel  output  3  debounced button level.
REQ-007 btnPress  output  3  one-cycle pulse on each accepted 0->1 transition.
REQ-008 btnSticky  output  3  latched press flag, held until cleared.

Function
REQ-009 Each bit SHALL pass through a 2-flop synchronizer; only the second flop output (syncBit) SHALL feed any further logic.
REQ-010 Each button SHALL run an independent 4-state FSM: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 IDLE_LOW: syncBit=1 -> WAIT_HIGH with counter=0; otherwise hold.
REQ-012 WAIT_HIGH: syncBit=0 -> IDLE_LOW; counter==DEBOUNCE_CYCLES-1 with syncBit=1 -> IDLE_HIGH; otherwise counter+1.
REQ-013 IDLE_HIGH: syncBit=0 -> WAIT_LOW with counter=0; otherwise hold.
REQ-014 WAIT_LOW: syncBit=1 -> IDLE_HIGH; counter==DEBOUNCE_CYCLES-1 with syncBit=0 -> IDLE_LOW; otherwise counter+1.
REQ-015 btnLevel SHALL be registered and equal 1 exactly when the state is IDLE_HIGH or WAIT_LOW.
REQ-016 btnPress SHALL be registered, high for exactly the one cycle following the WAIT_HIGH->IDLE_HIGH transition; no pulse on WAIT_LOW->IDLE_HIGH or on release.
REQ-017 Latency: with the edge that first samples btnRaw=1 numbered 1, btnPress and btnLevel SHALL rise after edge DEBOUNCE_CYCLES+3 if the input stays high throughout.
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES stable samples SHALL NOT change btnLevel or produce btnPress.
REQ-019 btnSticky[i] SHALL be set in the cycle btnPress[i] is set and cleared by pressClear[i]; if both occur on the same edge, set wins.
REQ-020 pressClear SHALL NOT affect btnLevel, btnPress or FSM state.
REQ-021 The counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 Simultaneous activity on several buttons SHALL be handled fully independently, with no priority between them.

Reset
REQ-023 While rst=1: synchronizer flops=0, state=IDLE_LOW, counter=0, btnLevel=0, btnPress=0, btnSticky=0.
REQ-024 Reset asserted mid-debounce SHALL abort the count.
REQ-025 After reset release, a button held high SHALL be treated as a new press (full REQ-017 latency, one btnPress pulse).

Structure
REQ-026 The following SHALL live in the shared Types package:
- NUM_BUTTONS = 3.
- ButtonVec typedef (logic [NUM_BUTTONS-1:0]).
- ButtonDebounceState enum (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW).
- Button index constants BTN_C = 0, BTN_U = 1, BTN_D = 2.
REQ-027 One sub-module, ButtonDebouncer, SHALL contain the synchronizer, FSM, counter and registered level/press outputs for a single button. It SHALL be instantiated NUM_BUTTONS times via a generate loop. Sticky logic SHALL remain in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: btnRaw=001 held from edge 1 -> btnPress=001 for exactly one cycle after edge 7; btnLevel=001 from then; btnSticky=001.
REQ-029 Bounce: btnRaw[1] toggles 1,0,1,0 on consecutive cycles, then holds 1 -> no pulse during the bounce; exactly one btnPress[1] pulse 7 edges after the final rise.
REQ-030 Release: from the pressed state, btnRaw=000 held -> btnLevel=000 after edge 7; no btnPress; btnSticky remains 001.
REQ-031 Clear collision: pressClear[0] asserted on the same edge btnPress[0] is set -> btnSticky[0]=1. pressClear[0] issued one cycle later -> btnSticky[0]=0.
REQ-032 Reset mid-debounce: rst pulsed at edge 4 while btnRaw=100 stays high -> all outputs 0 immediately; btnPress[2] occurs 7 edges after the first post-release edge.
REQ-033 Independence: btnC rises at edge 1 and btnD at edge 3 -> pulses on bit0 after edge 7 and bit2 after edge 9, no cross-interference.
